// File: rtl/pd_pkg.sv
// rtl/pd_pkg.sv - shared packet-identifier constants and PCIe generation encodings.
package pd_pkg;

  localparam int PD_LANES    = 64;
  localparam int PD_BYTE_W   = 8;
  localparam int PD_DW_BYTES = 4;

  typedef enum logic [2:0] {
    GEN1 = 3'b000,
    GEN2 = 3'b001,
    GEN3 = 3'b010,
    GEN4 = 3'b011,
    GEN5 = 3'b100
  } pd_gen_e;

endpackage

// File: rtl/pd_byte_fifo_if.sv
// rtl/pd_byte_fifo_if.sv - PIPE byte write side and DW read side of the byte fifo.
interface pd_byte_fifo_if
  import pd_pkg::*;
#(
  parameter int DEPTH_BYTES = 256
) ();

  logic                               w;
  logic [PD_LANES-1:0]                valid;
  logic [PD_LANES*PD_BYTE_W-1:0]      data_in;
  logic                               rd_en;
  logic [PD_DW_BYTES*PD_BYTE_W-1:0]   data_out;
  logic                               data_out_vld;
  logic                               full;
  logic [$clog2(DEPTH_BYTES):0]       level;
  logic                               overflow;

  modport master (
    output w, valid, data_in, rd_en,
    input  data_out, data_out_vld, full, level, overflow
  );

  modport slave (
    input  w, valid, data_in, rd_en,
    output data_out, data_out_vld, full, level, overflow
  );

endinterface

// File: rtl/pd_lane_count.sv
// rtl/pd_lane_count.sv - counts the contiguous run of valid lanes starting at lane 0.
module pd_lane_count
  import pd_pkg::*;
(
  input  logic [PD_LANES-1:0] mask,
  output logic [6:0]          wcnt
);

  logic run;

  // run drops at the first zero so any lanes above it never count
  always_comb begin
    wcnt = '0;
    run  = 1'b1;
    for (int i = 0; i < PD_LANES; i++) begin
      run  = run & mask[i];
      wcnt = wcnt + {6'd0, run};
    end
  end

endmodule

// File: rtl/pd_byte_fifo.sv
// rtl/pd_byte_fifo.sv - elastic buffer turning variable-width PIPE beats into show-ahead DW words.
module pd_byte_fifo
  import pd_pkg::*;
#(
  parameter int DEPTH_BYTES = 256,
  parameter int OUT_BYTES   = 4
) (
  input  logic           clk,
  input  logic           rst,
  pd_byte_fifo_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH_BYTES);
  localparam int LVL_W = PTR_W + 1;

  logic [PD_BYTE_W-1:0] mem [DEPTH_BYTES];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     level;
  logic                 overflow;
  logic [6:0]           wcnt;
  logic [LVL_W-1:0]     free_bytes;
  logic                 accept;
  logic                 pop;

  pd_lane_count u_lane_count (
    .mask (bus.valid),
    .wcnt (wcnt)
  );

  // acceptance looks only at the pre-pop level, so a same-cycle pop earns no credit
  assign free_bytes       = LVL_W'(DEPTH_BYTES) - level;
  assign accept           = bus.w && (free_bytes >= LVL_W'(wcnt));
  assign bus.data_out_vld = level >= LVL_W'(OUT_BYTES);
  assign bus.full         = free_bytes < LVL_W'(PD_LANES);
  assign bus.level        = level;
  assign bus.overflow     = overflow;
  assign pop              = bus.rd_en && bus.data_out_vld;

  // storage carries no reset; a flop array lets all lanes scatter in one cycle
  always_ff @(posedge clk) begin
    if (!rst && accept) begin
      for (int i = 0; i < PD_LANES; i++) begin
        if (i < int'(wcnt)) begin
          mem[wr_ptr + PTR_W'(i)] <= bus.data_in[i*PD_BYTE_W +: PD_BYTE_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + PTR_W'(wcnt);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(OUT_BYTES);
      end
      level <= level + (accept ? LVL_W'(wcnt) : '0) - (pop ? LVL_W'(OUT_BYTES) : '0);
      if (bus.w && !accept) begin
        overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.data_out = '0;
    for (int k = 0; k < OUT_BYTES; k++) begin
      bus.data_out[k*PD_BYTE_W +: PD_BYTE_W] = mem[rd_ptr + PTR_W'(k)];
    end
  end

endmodule

// File: doc/pd_byte_fifo.md
# pd_byte_fifo

Byte-granular elastic buffer between the generation controller and the packet identifier. Each cycle the write strobe `w` is high, it accepts the contiguous run of valid bytes from the 64-lane PIPE data bus, whose lane count varies with PCIe generation and is given by the lane-valid mask. It re-emits those bytes in arrival order as fixed 4-byte (DW) words for the identifier's framing logic. It absorbs the width mismatch between variable-width PIPE beats and the DW-oriented parser, and flags overflow.

## Interface
- `DEPTH_BYTES`, 256: storage depth in bytes; power of two, ≥ 128.
- `OUT_BYTES`, 4: bytes per output word; fixed at 4 for this design.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `w`  in  1  write strobe from generation controller; beat offered when high.
- `valid`  in  64  lane-valid mask; bit i qualifies byte lane i.
- `data_in`  in  512  PIPE data; lane i = `data_in[8i+7:8i]`.
- `rd_en`  in  1  consumer pop request.
- `data_out`  out  32  oldest 4 bytes; `[7:0]` = oldest.
- `data_out_vld`  out  1  at least 4 bytes stored.
- `full`  out  1  free space < 64 bytes (a maximum beat is not guaranteed to fit).
- `level`  out  log2(DEPTH_BYTES)+1  bytes currently stored.
- `overflow`  out  1  sticky; a beat was dropped for lack of space.

## Operation
- Write count `wcnt` = number of consecutive ones in `valid` starting at bit 0 (0..64). Bits above the first zero are ignored. An all-zero mask gives `wcnt` = 0.
- A beat is accepted when `w`=1 and `DEPTH_BYTES - level >= wcnt`, where `level` is the pre-pop value. The acceptance check is conservative and takes no credit for a same-cycle pop.
- On acceptance, lanes 0..wcnt-1 are written to `mem[wr_ptr .. wr_ptr+wcnt-1]`, modulo `DEPTH_BYTES`, and `wr_ptr` advances by `wcnt`.
- If the beat does not fit, the whole beat is dropped (never partially written), `overflow` is set, and pointers are unchanged.
- Pop occurs when `rd_en`=1 and `data_out_vld`=1. `rd_ptr` advances by 4. `rd_en` with `data_out_vld`=0 is ignored and has no side effects.
- `level_next = level + (accepted ? wcnt : 0) - (pop ? 4 : 0)`.
- Pointers are log2(DEPTH_BYTES) bits and wrap naturally. Byte reads and writes straddling the wrap are split correctly.
- `data_out` is show-ahead: bytes `mem[rd_ptr .. rd_ptr+3]`, modulo depth.
- `overflow` clears only on `rst`.
- No state machine. State is `wr_ptr`, `rd_ptr`, `level`, `overflow` and the storage.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge): `wr_ptr`=`rd_ptr`=0, `level`=0, `overflow`=0. Therefore `data_out_vld`=0 and `full`=0 in the following cycle. Storage is not reset. `data_out` is don't-care while `data_out_vld`=0.
- `rst` mid-operation discards all content and overrides the same-cycle write and pop.
- Write-to-read latency is 1 cycle. Bytes accepted at edge N are visible on `data_out` and counted in `level` after edge N.
- `data_out_vld`, `full` and `level` are derived from registered state only, with no combinational path from `w`, `valid` or `rd_en`.
- Simultaneous accept and pop in one cycle is legal. Both take effect at the same edge.
- When `level` = 1..3, `data_out_vld`=0. Residual bytes wait for further writes; there is no flush.

## Structure
- Shared package `pd_pkg`:
  - `PD_LANES`=64, `PD_BYTE_W`=8, `PD_DW_BYTES`=4.
  - Generation encodings `GEN1..GEN5` = 3'b000..3'b100, shared with the generation controller.
- One sub-module `pd_lane_count`: purely combinational mask → `wcnt` (7 bits) leading-ones counter, reused by the identifier.
- Storage is a flop array so that 64-byte scatter writes are possible.

## Test plan
- Reset then idle: `level`=0, `data_out_vld`=0, `full`=0, `overflow`=0.
- Gen1 mask (16 lanes) with bytes 0x00..0x0F, one beat, then 4 pops: words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C; `level` reads 16, 12, 8, 4, 0.
- Gen3 (64 lanes), 4 beats with no reads: `level`=256, `full`=1. A 5th beat is dropped, `overflow`=1 and `level` stays 256.
- Wrap: write 16 bytes, pop 4, repeat ≥ 20 times. The byte sequence out exactly equals the sequence in across the 255→0 boundary.
- Same-cycle write (32 bytes) and pop at `level`=4: `level`=32 next cycle and order is preserved.
- Non-thermometer mask 0x…00F7: `wcnt`=3, only lanes 0..2 stored. Assert `rst` mid-stream: `level`=0 next cycle and the subsequent write is read back correctly.
